// File: rtl/i2c_apb_pkg.sv
// Shared constants for the I2C APB slice: TX FIFO (this block), the future
// RX FIFO and the APB register block all take their defaults from here.
//   DATA_W_DEF        byte width on the controller data path
//   TX_FIFO_DEPTH_DEF TX FIFO entries (power of two, >= 2)
//   TX_FIFO_AF_DEF    almost_full threshold
//   fifo_cnt_w()      width of an occupancy count for a given depth
//                     (one extra bit so that count == depth is representable)
package i2c_apb_pkg;

  localparam int DATA_W_DEF        = 8;
  localparam int TX_FIFO_DEPTH_DEF = 16;
  localparam int TX_FIFO_AF_DEF    = 12;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int TX_FIFO_CNT_W_DEF = $clog2(TX_FIFO_DEPTH_DEF) + 1;

endpackage

// File: rtl/i2c_tx_fifo_if.sv
// Bus between the APB register block / I2C controller (master side) and the
// TX FIFO (slave side).
//   wr_en, wr_data    push request and byte from the APB register block
//   pop_req           controller fifo_tx_enable level
//   clr_err           clears the sticky overflow / underflow flags
//   data_out          head byte (first-word-fall-through)
//   empty, full, almost_full, count, overflow, underflow   status
interface i2c_tx_fifo_if
  import i2c_apb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = TX_FIFO_DEPTH_DEF
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              pop_req;
  logic              clr_err;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, pop_req, clr_err,
    input  data_out, empty, full, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, pop_req, clr_err,
    output data_out, empty, full, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/i2c_tx_fifo_rise_edge_det.sv
// Rising-edge detector: registers a level and emits a one-cycle pulse in the
// cycle the level is first seen high. RST_VAL=1 suppresses a pulse for a
// level that is already high when reset releases.
//   core_clk  clock
//   rst       synchronous active-high reset
//   level     input level
//   pulse     level & ~level_d (combinational, one cycle wide)
module rise_edge_det #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic core_clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_d;

  always_ff @(posedge core_clk) begin
    if (rst) level_d <= RST_VAL;
    else     level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/i2c_tx_fifo.sv
// TX data buffer feeding the I2C controller. The APB side pushes bytes; the
// controller pops one byte per rising edge of its fifo_tx_enable level. The
// head byte is always presented, registered, on data_out.
//   core_clk  clock
//   rst       synchronous active-high reset
//   bus       i2c_tx_fifo_if slave modport (push, pop level, status, errors)
module i2c_tx_fifo
  import i2c_apb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = TX_FIFO_DEPTH_DEF,
  parameter int AF_THRESH = TX_FIFO_AF_DEF
) (
  input  logic           core_clk,
  input  logic           rst,
  i2c_tx_fifo_if.slave   bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = fifo_cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  count_r, count_nxt;
  logic [DATA_W-1:0] data_out_r, head_nxt;
  logic              empty_r, full_r, af_r;
  logic              ovf_r, udf_r;
  logic              pop_fire, pop_ok, push_ok;

  rise_edge_det #(.RST_VAL(1'b1)) u_pop_edge (
    .core_clk (core_clk),
    .rst      (rst),
    .level    (bus.pop_req),
    .pulse    (pop_fire)
  );

  // A pop frees the slot a full-FIFO push needs, so both go through.
  assign pop_ok  = pop_fire & ~empty_r;
  assign push_ok = bus.wr_en & (~full_r | pop_ok);

  always_comb begin
    count_nxt  = count_r;
    rd_ptr_nxt = rd_ptr;
    head_nxt   = data_out_r;

    unique case ({push_ok, pop_ok})
      2'b10:   count_nxt = count_r + CNT_W'(1);
      2'b01:   count_nxt = count_r - CNT_W'(1);
      default: count_nxt = count_r;
    endcase

    if (pop_ok) rd_ptr_nxt = rd_ptr + ADDR_W'(1);

    // The new head is the byte being written this cycle whenever the write
    // lands on the next read slot (push into empty, or push+pop at count 1);
    // storage isn't updated until the edge, so bypass it.
    if (push_ok && (wr_ptr == rd_ptr_nxt))
      head_nxt = bus.wr_data;
    else if (count_nxt != '0)
      head_nxt = mem[rd_ptr_nxt];
  end

  always_ff @(posedge core_clk) begin
    if (push_ok) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      data_out_r <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      af_r       <= 1'b0;
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      rd_ptr     <= rd_ptr_nxt;
      count_r    <= count_nxt;
      data_out_r <= head_nxt;
      empty_r    <= (count_nxt == '0);
      full_r     <= (count_nxt == CNT_W'(DEPTH));
      af_r       <= (count_nxt >= CNT_W'(AF_THRESH));
      // New error beats a simultaneous clear.
      ovf_r      <= (bus.wr_en & ~push_ok) | (ovf_r & ~bus.clr_err);
      udf_r      <= (pop_fire & empty_r)   | (udf_r & ~bus.clr_err);
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.empty       = empty_r;
  assign bus.full        = full_r;
  assign bus.almost_full = af_r;
  assign bus.count       = count_r;
  assign bus.overflow    = ovf_r;
  assign bus.underflow   = udf_r;

endmodule
